// File: rtl/md_mode_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_mode_buf_pkg
//  Description : Shared constants and types for the intra mode ping-pong
//                buffer: mode width, level encodings, flat-address bases
//                and per-bank fill-state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_mode_buf_pkg;

    localparam int MODE_W  = 6;
    localparam int N8      = 64;
    localparam int N16     = 16;
    localparam int N32     = 4;
    localparam int N_ENTRY = 85;
    localparam int ADDR_W  = 7;

    // Read-side level select encoding
    localparam logic [1:0] LVL8  = 2'd0;
    localparam logic [1:0] LVL16 = 2'd1;
    localparam logic [1:0] LVL32 = 2'd2;
    localparam logic [1:0] LVL64 = 2'd3;

    // Flat bank address of entry 0 of each level
    localparam logic [ADDR_W-1:0] BASE8  = 7'd0;
    localparam logic [ADDR_W-1:0] BASE16 = 7'd64;
    localparam logic [ADDR_W-1:0] BASE32 = 7'd80;
    localparam logic [ADDR_W-1:0] BASE64 = 7'd84;

    // Per-bank fill state
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/md_mode_bank.sv
`default_nettype none
// ============================================================================
//  Module      : md_mode_bank
//  Description : One LCU worth of mode storage. Four write ports (one per
//                block level, address ranges disjoint) and one registered
//                read port. Storage is deliberately not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_mode_bank #(
    parameter int MODE_W  = 6,
    parameter int N_ENTRY = 85,
    parameter int ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we8,
    input  logic [ADDR_W-1:0] i_wa8,
    input  logic [MODE_W-1:0] i_wd8,
    input  logic              i_we16,
    input  logic [ADDR_W-1:0] i_wa16,
    input  logic [MODE_W-1:0] i_wd16,
    input  logic              i_we32,
    input  logic [ADDR_W-1:0] i_wa32,
    input  logic [MODE_W-1:0] i_wd32,
    input  logic              i_we64,
    input  logic [ADDR_W-1:0] i_wa64,
    input  logic [MODE_W-1:0] i_wd64,
    input  logic [ADDR_W-1:0] i_ra,
    output logic [MODE_W-1:0] o_rdata
);

    logic [MODE_W-1:0] r_mem [N_ENTRY];
    logic [MODE_W-1:0] r_rdata;

    // Level write ports never collide: each level owns its own address range
    always_ff @(posedge clk) begin
        if (i_we8)  r_mem[i_wa8]  <= i_wd8;
        if (i_we16) r_mem[i_wa16] <= i_wd16;
        if (i_we32) r_mem[i_wa32] <= i_wd32;
        if (i_we64) r_mem[i_wa64] <= i_wd64;
    end

    // Synchronous read port; only the output register is cleared by reset
    always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else     r_rdata <= r_mem[i_ra];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/md_mode_buf.sv
`default_nettype none
// ============================================================================
//  Module      : md_mode_buf
//  Description : Ping-pong buffer of best intra modes for one 64x64 LCU.
//                The mode-decision side streams modes into the write bank
//                while the prediction/RDO side randomly reads the other.
//                Tracks bank fill state and flags protocol errors (sticky).
//  Revision    : 1.0 - initial release
// ============================================================================
module md_mode_buf #(
    parameter int MODE_W = md_mode_buf_pkg::MODE_W,
    parameter int N8     = md_mode_buf_pkg::N8,
    parameter int N16    = md_mode_buf_pkg::N16,
    parameter int N32    = md_mode_buf_pkg::N32
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              md_ready,
    input  logic              mode8_vld,
    input  logic [MODE_W-1:0] mode8,
    input  logic              mode16_vld,
    input  logic [MODE_W-1:0] mode16,
    input  logic              mode32_vld,
    input  logic [MODE_W-1:0] mode32,
    input  logic              mode64_vld,
    input  logic [MODE_W-1:0] mode64,
    input  logic              md_finish,
    output logic              lcu_vld,
    input  logic [1:0]        rd_lvl,
    input  logic [5:0]        rd_idx,
    output logic [MODE_W-1:0] rd_mode,
    input  logic              rd_done,
    output logic              err_o
);
    import md_mode_buf_pkg::*;

    localparam int C8_W  = $clog2(N8 + 1);
    localparam int C16_W = $clog2(N16 + 1);
    localparam int C32_W = $clog2(N32 + 1);

    bank_state_t        r_state [2];
    logic               r_wbank, r_rbank;
    logic [C8_W-1:0]    r_cnt8;
    logic [C16_W-1:0]   r_cnt16;
    logic [C32_W-1:0]   r_cnt32;
    logic               r_cnt64;
    logic               r_err;
    logic               r_rsel;
    logic               r_rok;

    logic               w_acc8, w_acc16, w_acc32, w_acc64, w_any_acc;
    logic [C8_W-1:0]    w_nxt8;
    logic [C16_W-1:0]   w_nxt16;
    logic [C32_W-1:0]   w_nxt32;
    logic               w_nxt64;
    logic               w_fin, w_short, w_drop, w_fin_err;
    logic               w_rel, w_done_err;
    logic               w_rd_ok;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [ADDR_W-1:0]  w_idx_ext;
    logic [MODE_W-1:0]  w_rdata [2];

    assign md_ready = (r_state[r_wbank] != BANK_FULL);
    assign lcu_vld  = (r_state[r_rbank] == BANK_FULL);
    assign err_o    = r_err;

    // Write acceptance: bank writable and the level counter not yet full
    assign w_acc8    = mode8_vld  & md_ready & (r_cnt8  != C8_W'(N8));
    assign w_acc16   = mode16_vld & md_ready & (r_cnt16 != C16_W'(N16));
    assign w_acc32   = mode32_vld & md_ready & (r_cnt32 != C32_W'(N32));
    assign w_acc64   = mode64_vld & md_ready & ~r_cnt64;
    assign w_any_acc = w_acc8 | w_acc16 | w_acc32 | w_acc64;

    // Counts including this cycle's writes, so a finish with the last writes is complete
    assign w_nxt8  = r_cnt8  + C8_W'(w_acc8);
    assign w_nxt16 = r_cnt16 + C16_W'(w_acc16);
    assign w_nxt32 = r_cnt32 + C32_W'(w_acc32);
    assign w_nxt64 = r_cnt64 | w_acc64;
    assign w_short = (w_nxt8 != C8_W'(N8)) | (w_nxt16 != C16_W'(N16)) |
                     (w_nxt32 != C32_W'(N32)) | ~w_nxt64;

    assign w_fin      = md_finish & md_ready;
    assign w_drop     = (mode8_vld & ~w_acc8) | (mode16_vld & ~w_acc16) |
                        (mode32_vld & ~w_acc32) | (mode64_vld & ~w_acc64);
    assign w_fin_err  = (md_finish & ~md_ready) | (w_fin & w_short);
    assign w_rel      = rd_done & lcu_vld;
    assign w_done_err = rd_done & ~lcu_vld;

    assign w_idx_ext = {1'b0, rd_idx};

    // Map (level, index) onto the flat bank address and range-check it
    always_comb begin
        w_rd_ok   = 1'b0;
        w_rd_addr = '0;
        case (rd_lvl)
            LVL8: begin
                w_rd_ok   = (w_idx_ext < ADDR_W'(N8));
                w_rd_addr = BASE8 + w_idx_ext;
            end
            LVL16: begin
                w_rd_ok   = (w_idx_ext < ADDR_W'(N16));
                w_rd_addr = BASE16 + w_idx_ext;
            end
            LVL32: begin
                w_rd_ok   = (w_idx_ext < ADDR_W'(N32));
                w_rd_addr = BASE32 + w_idx_ext;
            end
            default: begin
                w_rd_ok   = (rd_idx == 6'd0);
                w_rd_addr = BASE64;
            end
        endcase
        if (!w_rd_ok) w_rd_addr = '0;
    end

    // Bank fill-state machines and ping-pong pointers
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_wbank    <= 1'b0;
            r_rbank    <= 1'b0;
        end else begin
            if (w_fin) begin
                r_state[r_wbank] <= BANK_FULL;
                r_wbank          <= ~r_wbank;
            end else if (w_any_acc && r_state[r_wbank] == BANK_EMPTY) begin
                r_state[r_wbank] <= BANK_FILLING;
            end
            // A FULL read bank is never the writable bank, so no collision here
            if (w_rel) begin
                r_state[r_rbank] <= BANK_EMPTY;
                r_rbank          <= ~r_rbank;
            end
        end
    end

    // Per-level write index counters, cleared when the LCU is closed
    always_ff @(posedge clk) begin
        if (rstn || w_fin) begin
            r_cnt8  <= '0;
            r_cnt16 <= '0;
            r_cnt32 <= '0;
            r_cnt64 <= 1'b0;
        end else begin
            r_cnt8  <= w_nxt8;
            r_cnt16 <= w_nxt16;
            r_cnt32 <= w_nxt32;
            r_cnt64 <= w_nxt64;
        end
    end

    // Sticky protocol error
    always_ff @(posedge clk) begin
        if (rstn) r_err <= 1'b0;
        else      r_err <= r_err | w_drop | w_fin_err | w_done_err | ~w_rd_ok;
    end

    // Remember which bank and whether the range was legal for the read in flight
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_rsel <= 1'b0;
            r_rok  <= 1'b0;
        end else begin
            r_rsel <= r_rbank;
            r_rok  <= w_rd_ok;
        end
    end

    assign rd_mode = r_rok ? w_rdata[r_rsel] : '0;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            md_mode_bank #(
                .MODE_W  (MODE_W),
                .N_ENTRY (N_ENTRY),
                .ADDR_W  (ADDR_W)
            ) u_bank (
                .clk     (clk),
                .rst     (rstn),
                .i_we8   (w_acc8  && (r_wbank == 1'(b))),
                .i_wa8   (BASE8  + ADDR_W'(r_cnt8)),
                .i_wd8   (mode8),
                .i_we16  (w_acc16 && (r_wbank == 1'(b))),
                .i_wa16  (BASE16 + ADDR_W'(r_cnt16)),
                .i_wd16  (mode16),
                .i_we32  (w_acc32 && (r_wbank == 1'(b))),
                .i_wa32  (BASE32 + ADDR_W'(r_cnt32)),
                .i_wd32  (mode32),
                .i_we64  (w_acc64 && (r_wbank == 1'(b))),
                .i_wa64  (BASE64),
                .i_wd64  (mode64),
                .i_ra    (w_rd_addr),
                .o_rdata (w_rdata[b])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_md_mode_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_mode_buf
//  Description : Directed self-checking bench for md_mode_buf.
//                LCU data pattern with offset k: mode8[i]=(i+k)%35,
//                mode16[j]=(j+2+k)%35, mode32[m]=(30+m+k)%35,
//                mode64=(26+k)%35.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_mode_buf;

    logic       clk = 1'b0;
    logic       rstn;
    logic       md_ready;
    logic       mode8_vld, mode16_vld, mode32_vld, mode64_vld;
    logic [5:0] mode8, mode16, mode32, mode64;
    logic       md_finish;
    logic       lcu_vld;
    logic [1:0] rd_lvl;
    logic [5:0] rd_idx;
    logic [5:0] rd_mode;
    logic       rd_done;
    logic       err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    md_mode_buf dut (
        .clk        (clk),
        .rstn       (rstn),
        .md_ready   (md_ready),
        .mode8_vld  (mode8_vld),
        .mode8      (mode8),
        .mode16_vld (mode16_vld),
        .mode16     (mode16),
        .mode32_vld (mode32_vld),
        .mode32     (mode32),
        .mode64_vld (mode64_vld),
        .mode64     (mode64),
        .md_finish  (md_finish),
        .lcu_vld    (lcu_vld),
        .rd_lvl     (rd_lvl),
        .rd_idx     (rd_idx),
        .rd_mode    (rd_mode),
        .rd_done    (rd_done),
        .err_o      (err_o)
    );

    // Hold reset for two edges; returns at a falling edge right after release
    task automatic apply_reset();
        rstn = 1'b1;
        mode8_vld = 0; mode16_vld = 0; mode32_vld = 0; mode64_vld = 0;
        mode8 = 0; mode16 = 0; mode32 = 0; mode64 = 0;
        md_finish = 0; rd_done = 0; rd_lvl = 0; rd_idx = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
    endtask

    // Stream n8 mode8 writes (all 16/4/1 of the other levels ride along)
    task automatic fill(input int off, input int n8, input bit fin_last);
        for (int i = 0; i < n8; i++) begin
            @(negedge clk);
            mode8_vld  = 1'b1;
            mode8      = 6'((i + off) % 35);
            mode16_vld = (i < 16);
            mode16     = 6'((i + 2 + off) % 35);
            mode32_vld = (i < 4);
            mode32     = 6'((30 + i + off) % 35);
            mode64_vld = (i == 0);
            mode64     = 6'((26 + off) % 35);
            md_finish  = fin_last && (i == n8 - 1);
        end
        @(negedge clk);
        mode8_vld = 0; mode16_vld = 0; mode32_vld = 0; mode64_vld = 0;
        md_finish = 0;
    endtask

    task automatic pulse_finish();
        md_finish = 1'b1;
        @(negedge clk);
        md_finish = 1'b0;
    endtask

    task automatic do_read(input int l, input int i, output logic [5:0] m);
        rd_lvl = 2'(l);
        rd_idx = 6'(i);
        @(negedge clk);
        m = rd_mode;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready: got %b expected 1", md_ready); end
        checks++; if (lcu_vld !== 1'b0) begin errors++; $display("FAIL reset_lcu_vld: got %b expected 0", lcu_vld); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
        checks++; if (rd_mode !== 6'd0) begin errors++; $display("FAIL reset_rd_mode: got %0d expected 0", rd_mode); end
    endtask

    task automatic test_fill_read();
        int lv[5] = '{0, 1, 2, 3, 0};
        int ix[5] = '{10, 3, 2, 0, 63};
        int ex[5] = '{10, 5, 32, 26, 28};
        logic [5:0] got;
        fill(0, 64, 1'b0);
        checks++; if (lcu_vld !== 1'b0) begin errors++; $display("FAIL fill_lcu_vld_before: got %b expected 0", lcu_vld); end
        pulse_finish();
        checks++; if (lcu_vld !== 1'b1) begin errors++; $display("FAIL fill_lcu_vld_after: got %b expected 1", lcu_vld); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL fill_md_ready: got %b expected 1", md_ready); end
        for (int k = 0; k < 5; k++) begin
            do_read(lv[k], ix[k], got);
            checks++;
            if (got !== 6'(ex[k])) begin errors++; $display("FAIL fill_read(%0d,%0d): got %0d expected %0d", lv[k], ix[k], got, ex[k]); end
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL fill_err: got %b expected 0", err_o); end
    endtask

    task automatic test_ping_pong();
        int lv[5] = '{0, 1, 2, 3, 0};
        int ix[5] = '{10, 3, 2, 0, 40};
        int ex[5] = '{17, 12, 4, 33, 12};
        logic [5:0] got;
        fill(7, 64, 1'b1);
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL pp_md_ready_full: got %b expected 0", md_ready); end
        checks++; if (lcu_vld !== 1'b1) begin errors++; $display("FAIL pp_lcu_vld: got %b expected 1", lcu_vld); end
        do_read(0, 10, got);
        checks++; if (got !== 6'd10) begin errors++; $display("FAIL pp_old_lcu_read: got %0d expected 10", got); end
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        checks++; if (lcu_vld !== 1'b1) begin errors++; $display("FAIL pp_lcu_vld_after_done: got %b expected 1", lcu_vld); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL pp_md_ready_after_done: got %b expected 1", md_ready); end
        for (int k = 0; k < 5; k++) begin
            do_read(lv[k], ix[k], got);
            checks++;
            if (got !== 6'(ex[k])) begin errors++; $display("FAIL pp_read(%0d,%0d): got %0d expected %0d", lv[k], ix[k], got, ex[k]); end
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL pp_err: got %b expected 0", err_o); end
    endtask

    task automatic test_back_to_back();
        int lv[5] = '{0, 1, 2, 3, 0};
        int ix[5] = '{10, 3, 2, 0, 0};
        int ex[5] = '{23, 18, 10, 4, 13};
        logic [5:0] got;
        fill(13, 64, 1'b0);
        md_finish = 1'b1;
        rd_done   = 1'b1;
        @(negedge clk);
        md_finish = 1'b0;
        rd_done   = 1'b0;
        checks++; if (lcu_vld !== 1'b1) begin errors++; $display("FAIL b2b_lcu_vld: got %b expected 1", lcu_vld); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL b2b_md_ready: got %b expected 1", md_ready); end
        for (int k = 0; k < 5; k++) begin
            do_read(lv[k], ix[k], got);
            checks++;
            if (got !== 6'(ex[k])) begin errors++; $display("FAIL b2b_read(%0d,%0d): got %0d expected %0d", lv[k], ix[k], got, ex[k]); end
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", err_o); end
    endtask

    task automatic test_write_when_full();
        logic [5:0] got;
        fill(20, 64, 1'b1);
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL wfull_md_ready: got %b expected 0", md_ready); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL wfull_err_before: got %b expected 0", err_o); end
        mode8_vld = 1'b1;
        mode8     = 6'd34;
        @(negedge clk);
        mode8_vld = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL wfull_err_after: got %b expected 1", err_o); end
        do_read(0, 0, got);
        checks++; if (got !== 6'd13) begin errors++; $display("FAIL wfull_read_intact: got %0d expected 13", got); end
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL wfull_md_ready_after: got %b expected 1", md_ready); end
        do_read(0, 10, got);
        checks++; if (got !== 6'd30) begin errors++; $display("FAIL wfull_read_lcu3_8: got %0d expected 30", got); end
        do_read(3, 0, got);
        checks++; if (got !== 6'd11) begin errors++; $display("FAIL wfull_read_lcu3_64: got %0d expected 11", got); end
    endtask

    task automatic test_overflow();
        logic [5:0] got;
        apply_reset();
        fill(0, 64, 1'b0);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ovf_err_before: got %b expected 0", err_o); end
        mode8_vld = 1'b1;
        mode8     = 6'd34;
        @(negedge clk);
        mode8_vld = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ovf_err_after: got %b expected 1", err_o); end
        pulse_finish();
        checks++; if (lcu_vld !== 1'b1) begin errors++; $display("FAIL ovf_lcu_vld: got %b expected 1", lcu_vld); end
        do_read(0, 0, got);
        checks++; if (got !== 6'd0) begin errors++; $display("FAIL ovf_read_idx0: got %0d expected 0", got); end
        do_read(0, 63, got);
        checks++; if (got !== 6'd28) begin errors++; $display("FAIL ovf_read_idx63: got %0d expected 28", got); end
    endtask

    task automatic test_short_lcu();
        logic [5:0] got;
        apply_reset();
        fill(0, 63, 1'b0);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL short_err_before: got %b expected 0", err_o); end
        pulse_finish();
        checks++; if (lcu_vld !== 1'b1) begin errors++; $display("FAIL short_lcu_vld: got %b expected 1", lcu_vld); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL short_err_after: got %b expected 1", err_o); end
        do_read(0, 62, got);
        checks++; if (got !== 6'd27) begin errors++; $display("FAIL short_read: got %0d expected 27", got); end
    endtask

    task automatic test_read_errors();
        logic [5:0] got;
        apply_reset();
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rderr_done_err: got %b expected 1", err_o); end
        checks++; if (lcu_vld !== 1'b0) begin errors++; $display("FAIL rderr_done_lcu_vld: got %b expected 0", lcu_vld); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL rderr_done_md_ready: got %b expected 1", md_ready); end
        apply_reset();
        do_read(2, 5, got);
        checks++; if (got !== 6'd0) begin errors++; $display("FAIL rderr_range32_mode: got %0d expected 0", got); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rderr_range32_err: got %b expected 1", err_o); end
        // Address 84 of bank 0 still holds a stale 26 from the previous fill
        apply_reset();
        do_read(1, 20, got);
        checks++; if (got !== 6'd0) begin errors++; $display("FAIL rderr_range16_mode: got %0d expected 0", got); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rderr_range16_err: got %b expected 1", err_o); end
        rd_lvl = 0;
        rd_idx = 0;
    endtask

    task automatic test_reset_mid_fill();
        int lv[5] = '{0, 0, 0, 1, 3};
        int ix[5] = '{0, 39, 63, 0, 0};
        int ex[5] = '{5, 9, 33, 7, 31};
        logic [5:0] got;
        apply_reset();
        fill(0, 40, 1'b0);
        apply_reset();
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL mid_md_ready: got %b expected 1", md_ready); end
        checks++; if (lcu_vld !== 1'b0) begin errors++; $display("FAIL mid_lcu_vld: got %b expected 0", lcu_vld); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err_o); end
        fill(5, 64, 1'b0);
        pulse_finish();
        checks++; if (lcu_vld !== 1'b1) begin errors++; $display("FAIL mid_lcu_vld_after: got %b expected 1", lcu_vld); end
        for (int k = 0; k < 5; k++) begin
            do_read(lv[k], ix[k], got);
            checks++;
            if (got !== 6'(ex[k])) begin errors++; $display("FAIL mid_read(%0d,%0d): got %0d expected %0d", lv[k], ix[k], got, ex[k]); end
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_err_after: got %b expected 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_ping_pong();
        test_back_to_back();
        test_write_when_full();
        test_overflow();
        test_short_lcu();
        test_read_errors();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_mode_buf.md
Name: md_mode_buf

Overview:
- Downstream of the intra mode-decision top. Captures the streamed best modes for one 64x64 LCU: 64 8x8, 16 16x16, 4 32x32 and 1 64x64.
- Ping-pong buffer: the next LCU's decision runs while the intra prediction/RDO stage randomly reads the previous LCU's modes.
- Tracks per-bank fill state, releases a bank when the consumer signals done, and flags protocol errors.

Parameters:
MODE_W, 6, width of one mode code (0 planar, 1 DC, 2..34 angular)
N8, 64, number of 8x8 entries per LCU
N16, 16, number of 16x16 entries per LCU
N32, 4, number of 32x32 entries per LCU

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-high (codebase port name kept)
md_ready  out  1  write bank available; decision may start the next LCU
mode8_vld  in  1  mode8 valid this cycle
mode8  in  6  8x8 best mode, z-order
mode16_vld  in  1  mode16 valid
mode16  in  6  16x16 best mode, z-order
mode32_vld  in  1  mode32 valid
mode32  in  6  32x32 best mode, z-order
mode64_vld  in  1  mode64 valid
mode64  in  6  64x64 best mode
md_finish  in  1  LCU decision complete pulse
lcu_vld  out  1  read bank holds a complete LCU
rd_lvl  in  2  0:8x8 1:16x16 2:32x32 3:64x64
rd_idx  in  6  z-order index within level
rd_mode  out  6  mode read, 1-cycle latency
rd_done  in  1  consumer finished; release read bank
err_o  out  1  sticky protocol error

Behaviour:
- Storage: 2 banks x 85 entries x 6 b (64+16+4+1), flat address = level base (0, 64, 80, 84) + index.
- Per-bank state:
  - EMPTY -> FILLING on the first accepted write.
  - FILLING -> FULL on md_finish.
  - FULL -> EMPTY on rd_done while the bank is the read bank.
- Pointers wbank and rbank, each 1 b, reset to 0.
- Write side:
  - Per-level write counters (7/5/3/1 b) assign indices sequentially. Counters clear on md_finish.
  - Writes at different levels in the same cycle are all accepted.
  - md_ready = (state[wbank] != FULL).
- Overflow/drop:
  - A write to a level whose counter already equals its N is dropped and sets err_o.
  - Any write, or md_finish, while md_ready=0 is dropped and sets err_o.
- md_finish with any counter short of N: the bank still goes FULL, err_o is set, and unwritten entries keep stale data. md_finish sets wbank <= ~wbank.
- Read side:
  - lcu_vld = (state[rbank] == FULL).
  - rd_mode <= mem[rbank][addr] every cycle; it is don't-care when lcu_vld=0.
  - rd_idx beyond the level range (>=N) returns 0 and sets err_o.
  - rd_done with lcu_vld=0 is ignored and sets err_o.
  - rd_done with lcu_vld=1 sets bank EMPTY and rbank <= ~rbank.
- Simultaneous md_finish and rd_done (different banks): both take effect in the same cycle.
- Same-bank hazard cannot occur: writes are disabled while the bank is FULL.
- md_finish in the same cycle as the last writes: the writes land first, then the counters clear.
- Reset (any time, including mid-LCU):
  - Both banks EMPTY, pointers 0, counters 0, err_o 0, rd_mode 0.
  - md_ready=1, lcu_vld=0.
  - Memory contents are not cleared.
- Latency: the first lcu_vld is asserted the cycle after md_finish.

Decomposition:
- Shared package holds:
  - MODE_W.
  - Level encodings (LVL8=0, LVL16=1, LVL32=2, LVL64=3).
  - Base offsets (0, 64, 80, 84).
  - Entry count 85.
  - Bank state encodings (EMPTY/FILLING/FULL).
- One sub-module, md_mode_bank: a single 85x6 register bank with 4 write ports (one per level) and 1 synchronous read port. It is instantiated twice; the top holds the FSMs, counters and error logic.

Test Plan:
- Reset, fill LCU0 with mode8[i]=i%35, mode16[j]=(j+2), mode32=30..33, mode64=26, then pulse md_finish -> lcu_vld=1 the next cycle. Reads at (0,10)=10, (1,3)=5, (2,2)=32, (3,0)=26, each 1 cycle later. err_o=0.
- Ping-pong: fill LCU1 while LCU0 is unread, then md_finish -> md_ready=0. A 65th write is dropped and err_o=1. Pulse rd_done -> lcu_vld stays 1 and reads now return LCU1 data. md_ready=1.
- Simultaneous md_finish (LCU2) and rd_done (LCU1) in the same cycle -> both banks transition, no error, and LCU2 is readable next.
- md_finish after only 63 mode8 writes -> lcu_vld=1 and err_o=1.
- rd_done with lcu_vld=0 -> ignored, err_o=1. rd_lvl=2, rd_idx=5 -> rd_mode=0, err_o=1.
- Assert rstn mid-fill (40 mode8 writes done), then refill -> md_ready=1, lcu_vld=0, err_o=0. A complete refill reads back correct values starting at index 0.
